// File: rtl/rf_scoreboard.sv
// rf_scoreboard: register file with a per-register busy scoreboard, a
// write-back bypass on every read port and an issue-stall generator for
// decode. x0 is hard-wired to zero and can never become busy.
module rf_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int NR_READ        = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NR_READ-1:0]                 rd_en,
    input  logic [NR_READ*REG_ADDR_WIDTH-1:0]  rd_addr,
    output logic [NR_READ*DATA_WIDTH-1:0]      rd_data,
    output logic [NR_READ-1:0]                 rd_busy,
    input  logic                               iss_valid,
    input  logic                               iss_wen,
    input  logic [REG_ADDR_WIDTH-1:0]          iss_rd,
    output logic                               iss_stall,
    input  logic                               wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0]          wb_addr,
    input  logic [DATA_WIDTH-1:0]              wb_data,
    input  logic                               flush,
    output logic [REG_ADDR_WIDTH:0]            busy_cnt,
    output logic                               sb_err
);

    localparam int NREG = 1 << REG_ADDR_WIDTH;
    localparam int CW   = REG_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [DATA_WIDTH-1:0]          r_rf [NREG];
    logic [NREG-1:0]                r_busy;
    logic [CW-1:0]                  r_busy_cnt;
    logic                           r_sb_err;

    logic                           w_wq;
    logic [NREG-1:0]                w_wb_hit;
    logic [NREG-1:0]                w_ebusy;
    logic [NREG-1:0]                w_busy_nxt;
    logic [NR_READ*DATA_WIDTH-1:0]  w_rd_data;
    logic [NR_READ-1:0]             w_rd_busy;
    logic                           w_iss_stall;
    logic                           w_accept;
    logic                           w_set;
    logic                           w_clr;
    logic                           w_cnt_inc;
    logic                           w_cnt_dec;

    assign w_wq = wb_valid & (wb_addr != '0);

    // One-hot of the register being written back this cycle (empty for x0).
    always_comb begin
        w_wb_hit = '0;
        if (w_wq) begin
            w_wb_hit[wb_addr] = 1'b1;
        end
    end

    // A producer completing this cycle no longer blocks its consumers.
    assign w_ebusy = r_busy & ~w_wb_hit;

    // Read ports: x0 is zero, then the write-back bypass, then the array.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int k = 0; k < NR_READ; k++) begin
            if (rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == '0) begin
                w_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if (w_wq && (wb_addr == rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH])) begin
                w_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wb_data;
            end else begin
                w_rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
                    r_rf[rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
            end
            w_rd_busy[k] = rd_en[k] & w_ebusy[rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
        end
    end

    assign w_iss_stall = iss_valid & ((|w_rd_busy) | (iss_wen & w_ebusy[iss_rd]));
    assign w_accept    = iss_valid & ~w_iss_stall & ~flush;
    assign w_set       = w_accept & iss_wen & (iss_rd != '0);
    assign w_clr       = w_wq & r_busy[wb_addr];

    // An accepted set can only target a busy register when that same register
    // is being written back now (otherwise WAW would have stalled it), so the
    // count moves only for a free target, and a clear is cancelled by a re-set.
    assign w_cnt_inc = w_set & ~r_busy[iss_rd];
    assign w_cnt_dec = w_clr & ~(w_set & (iss_rd == wb_addr));

    // Next busy vector: flush beats set, set beats the write-back clear.
    always_comb begin
        w_busy_nxt = r_busy & ~w_wb_hit;
        if (w_set) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        if (flush) begin
            w_busy_nxt = '0;
        end
    end

    // Scoreboard state, busy count and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
            r_sb_err   <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (flush) begin
                r_busy_cnt <= '0;
            end else if (w_cnt_inc && !w_cnt_dec) begin
                r_busy_cnt <= r_busy_cnt + CNT_ONE;
            end else if (w_cnt_dec && !w_cnt_inc) begin
                r_busy_cnt <= r_busy_cnt - CNT_ONE;
            end
            if (w_wq && !r_busy[wb_addr] && !flush) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    // Register array write; performed even on flush or for a non-busy target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wq) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    assign rd_data   = w_rd_data;
    assign rd_busy   = w_rd_busy;
    assign iss_stall = w_iss_stall;
    assign busy_cnt  = r_busy_cnt;
    assign sb_err    = r_sb_err;

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised register file with per-register busy scoreboard, write-back bypass and an issue-stall generator. It replaces the single-cycle decoder's embedded register file when the core is split into decode / execute / write-back stages. The block tracks which architectural registers have an in-flight producer and tells decode when to hold an instruction. It supplies same-cycle-forwarded operands on a configurable number of read ports.

## Interface
- REG_ADDR_WIDTH, 5, register address width; NREG = 1 << REG_ADDR_WIDTH (4 gives RV32E)
- DATA_WIDTH, 32, register data width
- NR_READ, 2, number of read ports (1..4)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- rd_en  input  NR_READ  port k reads / hazard-checks when bit k = 1
- rd_addr  input  NR_READ*REG_ADDR_WIDTH  port k address in slice k
- rd_data  output  NR_READ*DATA_WIDTH  port k data (forwarded)
- rd_busy  output  NR_READ  port k source still pending after bypass
- iss_valid  input  1  decode presents an instruction
- iss_wen  input  1  instruction writes a register
- iss_rd  input  REG_ADDR_WIDTH  destination register
- iss_stall  output  1  instruction must be held this cycle
- wb_valid  input  1  write-back this cycle
- wb_addr  input  REG_ADDR_WIDTH  write-back register
- wb_data  input  DATA_WIDTH  write-back value
- flush  input  1  squash all in-flight producers
- busy_cnt  output  REG_ADDR_WIDTH+1  number of busy registers
- sb_err  output  1  sticky: write-back to a non-busy register

## Operation
- State: rf[NREG], busy[NREG], sb_err. x0 reads 0 and is never written. busy[0] is never set.
- Write qualification: wq = wb_valid & (wb_addr != 0).
- Read port k is combinational:
  - rd_data = 0 if addr = 0.
  - Otherwise rd_data = wb_data if wq & wb_addr = addr (bypass).
  - Otherwise rd_data = rf[addr].
- Effective busy: ebusy[r] = busy[r] & ~(wq & wb_addr = r).
- rd_busy[k] = rd_en[k] & ebusy[rd_addr_k]. Ports with rd_en = 0 report 0.
- iss_stall = iss_valid & (|rd_busy | (iss_wen & ebusy[iss_rd])). The iss_wen term is the WAW check.
- accept = iss_valid & ~iss_stall & ~flush.
- Next-state busy[r], in priority order:
  1. flush → 0
  2. accept & iss_wen & iss_rd = r ≠ 0 → 1 (set wins over same-cycle clear)
  3. wq & wb_addr = r → 0
  4. otherwise hold
- rf[wb_addr] ← wb_data when wq. This applies regardless of busy state and of flush.
- sb_err ← 1 when wq & ~busy[wb_addr] & ~flush. Only reset clears it.
- busy_cnt is a registered popcount of busy, updated incrementally: +1 on set, −1 on clear, net 0 when both hit the same register. It goes to 0 on flush and must always equal popcount(busy).
- At most one producer per register is outstanding. WAW stalling guarantees this; no per-register counters are needed.

## Timing
- Reads, rd_busy and iss_stall are combinational from the current state and the same-cycle write-back. Zero-cycle read latency.
- Write, busy set/clear, busy_cnt and sb_err update at the rising clk edge. They are visible to reads the next cycle, or the same cycle through bypass.
- Reset (rst = 0) takes effect immediately, independent of clk:
  - rf all 0, busy all 0, busy_cnt = 0, sb_err = 0.
  - Outputs then read rd_data = 0, rd_busy = 0, iss_stall = 0.
- Reset asserted mid-operation discards all pending producers. After release, write-backs arriving for them set sb_err.
- flush and write-back in the same cycle: the write is performed, busy ends at 0, sb_err is not set.
- Issue and write-back to the same register in the same cycle:
  - the stall check sees the register as free;
  - the register ends busy;
  - busy_cnt is unchanged.
- A stalled instruction must be re-presented unchanged. The block keeps no memory of stalled requests.

## Test plan
- Reset / x0:
  - Hold rst = 0 and drive wb x0 = 0xDEAD.
  - Required: rd_data = 0, busy_cnt = 0. After release, reading x0 returns 0.
- RAW stall and bypass:
  - Issue x5 (accepted, busy_cnt = 1). Next cycle, port 0 reads x5 with rd_en = 1 → iss_stall = 1.
  - Then wb x5 = 0x1234 in the same cycle → rd_data0 = 0x1234, rd_busy0 = 0, iss_stall = 0, and busy_cnt returns to 0 after the edge.
- WAW:
  - x7 busy; issue with iss_wen, iss_rd = 7 and rd_en = 0 → iss_stall = 1.
  - Same with wb x7 in that cycle → accepted; x7 stays busy; busy_cnt stays 1.
- Flush:
  - Set x1, x2, x3 busy (busy_cnt = 3). Assert flush together with wb x2 = 0x55.
  - Required: busy_cnt = 0, sb_err = 0, x2 reads 0x55.
  - A later wb x1 → sb_err = 1.
- Mid-op async reset:
  - With x4 busy and rf[4] = 0x99, pulse rst low between clock edges.
  - Required: busy_cnt = 0 and rd x4 = 0 immediately.
- Parameter sweep:
  - REG_ADDR_WIDTH = 4, NR_READ = 3 with random issue/wb/flush traffic, checked against a reference model.
  - Required: busy_cnt = popcount(busy) every cycle; no mismatch on any rd_data or iss_stall.
